control_unit: RTL and testbench

//  Multi-cycle FSM sequencing the K&S 16-bit processor.

---
 rtl/control_unit_if.sv | 62 ++++++
 rtl/control_unit.sv | 181 ++++++++++++++++++
 tb/tb_control_unit.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
// K&S processor instruction classes and the control-unit <-> datapath bundle.
// The package sits here because the interface is the first consumer of the type.
package k_and_s_pkg;

    typedef enum logic [3:0] {
        I_NOP    = 4'd0,
        I_LOAD   = 4'd1,
        I_STORE  = 4'd2,
        I_MOVE   = 4'd3,
        I_ADD    = 4'd4,
        I_SUB    = 4'd5,
        I_AND    = 4'd6,
        I_OR     = 4'd7,
        I_BRANCH = 4'd8,
        I_BZERO  = 4'd9,
        I_BNZERO = 4'd10,
        I_BNEG   = 4'd11,
        I_BNNEG  = 4'd12,
        I_HALT   = 4'd13
    } decoded_instruction_type;

endpackage

// Control/status bundle between the control unit (master) and the datapath/RAM (slave).
interface control_unit_if #(
    parameter int unsigned COUNT_W = 16
);
    import k_and_s_pkg::*;

    // status from the datapath
    decoded_instruction_type decoded_instruction;
    logic                    zero_op;
    logic                    neg_op;
    logic                    unsigned_overflow;
    logic                    signed_overflow;

    // control to the datapath / RAM
    logic                    branch;
    logic                    pc_enable;
    logic                    ir_enable;
    logic                    addr_sel;
    logic                    c_sel;
    logic [1:0]              operation;
    logic                    write_reg_enable;
    logic                    flags_reg_enable;
    logic                    ram_write_enable;
    logic                    halt;
    logic [COUNT_W-1:0]      retired_count;

    modport master (
        input  decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
        output branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
               write_reg_enable, flags_reg_enable, ram_write_enable, halt, retired_count
    );

    modport slave (
        output decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
        input  branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
               write_reg_enable, flags_reg_enable, ram_write_enable, halt, retired_count
    );

endinterface

// File: rtl/control_unit.sv
// Multi-cycle sequencer for the K&S 16-bit processor: fetch, latch, decode,
// then one execute flow per instruction class. Outputs are Moore-decoded from
// the state; only BR_COND also looks at the live flags.
module control_unit #(
    parameter int unsigned MEM_WAIT_CYCLES = 1,
    parameter int unsigned COUNT_W         = 16
) (
    input  logic           clk,
    input  logic           rst_n,   // active-high asynchronous reset despite the name
    control_unit_if.master bus
);
    import k_and_s_pkg::*;

    localparam int unsigned WAIT_W = (MEM_WAIT_CYCLES > 1) ? $clog2(MEM_WAIT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_FETCH,
        S_LATCH,
        S_DECODE,
        S_LD_WAIT,
        S_LD_WB,
        S_ST,
        S_ALU,
        S_BR,
        S_BR_COND,
        S_HALT
    } state_t;

    state_t                  state_q, state_d;
    logic [WAIT_W-1:0]       wait_q, wait_d;
    decoded_instruction_type op_q, op_d;
    logic [COUNT_W-1:0]      count_q, count_d;
    logic                    retire;
    logic                    taken;

    // overflow flags are carried on the bus for observation only
    logic unused_ovf;
    assign unused_ovf = bus.unsigned_overflow ^ bus.signed_overflow;

    // state, wait counter, latched instruction class and retire counter
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            op_q    <= I_NOP;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            op_q    <= op_d;
            count_q <= count_d;
        end
    end

    // next-state selection; the instruction class is captured in DECODE so the
    // execute states stay purely state-decoded
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        op_d    = op_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = S_LATCH;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_LATCH: state_d = S_DECODE;
            S_DECODE: begin
                op_d = bus.decoded_instruction;
                case (bus.decoded_instruction)
                    I_LOAD:  state_d = S_LD_WAIT;
                    I_STORE: state_d = S_ST;
                    I_MOVE, I_ADD, I_SUB, I_AND, I_OR:
                             state_d = S_ALU;
                    I_BRANCH: state_d = S_BR;
                    I_BZERO, I_BNZERO, I_BNEG, I_BNNEG:
                             state_d = S_BR_COND;
                    I_HALT: begin
                        state_d = S_HALT;
                        retire  = 1'b1;
                    end
                    default: begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                endcase
            end
            S_LD_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = S_LD_WB;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_LD_WB, S_ST, S_ALU, S_BR, S_BR_COND: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
        count_d = count_q + COUNT_W'(retire);
    end

    // branch condition for BR_COND from the latched class and the live flags
    always_comb begin
        taken = 1'b0;
        case (op_q)
            I_BZERO:  taken = bus.zero_op;
            I_BNZERO: taken = ~bus.zero_op;
            I_BNEG:   taken = bus.neg_op;
            I_BNNEG:  taken = ~bus.neg_op;
            default:  taken = 1'b0;
        endcase
    end

    // control outputs decoded from the current state
    always_comb begin
        bus.branch           = 1'b0;
        bus.pc_enable        = 1'b0;
        bus.ir_enable        = 1'b0;
        bus.addr_sel         = 1'b1;
        bus.c_sel            = 1'b0;
        bus.operation        = 2'b00;
        bus.write_reg_enable = 1'b0;
        bus.flags_reg_enable = 1'b0;
        bus.ram_write_enable = 1'b0;
        bus.halt             = 1'b0;
        case (state_q)
            S_LATCH: begin
                bus.ir_enable = 1'b1;
                bus.pc_enable = 1'b1;
            end
            S_LD_WAIT: bus.addr_sel = 1'b0;
            S_LD_WB: begin
                bus.addr_sel         = 1'b0;
                bus.c_sel            = 1'b1;
                bus.write_reg_enable = 1'b1;
            end
            S_ST: begin
                bus.addr_sel         = 1'b0;
                bus.ram_write_enable = 1'b1;
            end
            S_ALU: begin
                bus.write_reg_enable = 1'b1;
                bus.flags_reg_enable = 1'b1;
                case (op_q)
                    I_ADD:   bus.operation = 2'b01;
                    I_SUB:   bus.operation = 2'b10;
                    I_AND:   bus.operation = 2'b11;
                    I_OR:    bus.operation = 2'b00;
                    default: begin
                        bus.operation        = 2'b00;
                        bus.flags_reg_enable = 1'b0;
                    end
                endcase
            end
            S_BR: begin
                bus.addr_sel  = 1'b0;
                bus.pc_enable = 1'b1;
                bus.branch    = 1'b1;
            end
            S_BR_COND: begin
                bus.addr_sel  = 1'b0;
                bus.pc_enable = taken;
                bus.branch    = taken;
            end
            S_HALT:  bus.halt = 1'b1;
            default: ;
        endcase
    end

    assign bus.retired_count = count_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: three instances (W=1, W=2, and W=1 with a 4-bit
// counter) checked against per-instruction expected output traces.
module tb_control_unit;
    import k_and_s_pkg::*;

    typedef logic [10:0] vec_t;  // {branch,pc_en,ir_en,addr_sel,c_sel,op[1:0],wr,fl,rw,halt}

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst [3];
    decoded_instruction_type dec [3];
    logic                    zf  [3];
    logic                    nf  [3];
    logic                    uo  [3];
    logic                    so  [3];

    control_unit_if #(.COUNT_W(16)) if0 ();
    control_unit_if #(.COUNT_W(16)) if1 ();
    control_unit_if #(.COUNT_W(4))  if2 ();

    control_unit #(.MEM_WAIT_CYCLES(1), .COUNT_W(16)) dut0 (.clk(clk), .rst_n(rst[0]), .bus(if0.master));
    control_unit #(.MEM_WAIT_CYCLES(2), .COUNT_W(16)) dut1 (.clk(clk), .rst_n(rst[1]), .bus(if1.master));
    control_unit #(.MEM_WAIT_CYCLES(1), .COUNT_W(4))  dut2 (.clk(clk), .rst_n(rst[2]), .bus(if2.master));

    assign if0.decoded_instruction = dec[0];
    assign if0.zero_op = zf[0];
    assign if0.neg_op = nf[0];
    assign if0.unsigned_overflow = uo[0];
    assign if0.signed_overflow = so[0];
    assign if1.decoded_instruction = dec[1];
    assign if1.zero_op = zf[1];
    assign if1.neg_op = nf[1];
    assign if1.unsigned_overflow = uo[1];
    assign if1.signed_overflow = so[1];
    assign if2.decoded_instruction = dec[2];
    assign if2.zero_op = zf[2];
    assign if2.neg_op = nf[2];
    assign if2.unsigned_overflow = uo[2];
    assign if2.signed_overflow = so[2];

    vec_t        obs0, obs1, obs2;
    logic [15:0] cnt0, cnt1, cnt2;
    assign obs0 = {if0.branch, if0.pc_enable, if0.ir_enable, if0.addr_sel, if0.c_sel, if0.operation,
                   if0.write_reg_enable, if0.flags_reg_enable, if0.ram_write_enable, if0.halt};
    assign obs1 = {if1.branch, if1.pc_enable, if1.ir_enable, if1.addr_sel, if1.c_sel, if1.operation,
                   if1.write_reg_enable, if1.flags_reg_enable, if1.ram_write_enable, if1.halt};
    assign obs2 = {if2.branch, if2.pc_enable, if2.ir_enable, if2.addr_sel, if2.c_sel, if2.operation,
                   if2.write_reg_enable, if2.flags_reg_enable, if2.ram_write_enable, if2.halt};
    assign cnt0 = if0.retired_count;
    assign cnt1 = if1.retired_count;
    assign cnt2 = {12'd0, if2.retired_count};

    int unsigned vectors;
    int unsigned miscompares;
    vec_t        exp_q[$];
    vec_t        got_q[$];
    int          wk  [3] = '{1, 2, 1};
    int          cwk [3] = '{16, 16, 4};

    function automatic vec_t get_obs(input int k);
        case (k)
            0:       return obs0;
            1:       return obs1;
            default: return obs2;
        endcase
    endfunction

    function automatic logic [15:0] get_cnt(input int k);
        case (k)
            0:       return cnt0;
            1:       return cnt1;
            default: return cnt2;
        endcase
    endfunction

    function automatic vec_t v(input logic br, input logic pc, input logic ir, input logic as,
                               input logic cs, input logic [1:0] op, input logic wr,
                               input logic fl, input logic rw, input logic h);
        return {br, pc, ir, as, cs, op, wr, fl, rw, h};
    endfunction

    // Expected per-cycle outputs of one instruction, starting at its first FETCH
    // cycle and ending at its last cycle before the next FETCH (or entry to HALT).
    function automatic void build_exp(input decoded_instruction_type ins, input int w,
                                      input logic z, input logic n);
        logic t;
        vec_t idle;
        idle = v(0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0);
        exp_q.delete();
        for (int i = 0; i < w; i++) exp_q.push_back(idle);
        exp_q.push_back(v(0, 1, 1, 1, 0, 2'b00, 0, 0, 0, 0));
        exp_q.push_back(idle);
        t = 1'b0;
        case (ins)
            I_LOAD: begin
                for (int i = 0; i < w; i++) exp_q.push_back(v(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
                exp_q.push_back(v(0, 0, 0, 0, 1, 2'b00, 1, 0, 0, 0));
            end
            I_STORE:  exp_q.push_back(v(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0));
            I_MOVE:   exp_q.push_back(v(0, 0, 0, 1, 0, 2'b00, 1, 0, 0, 0));
            I_ADD:    exp_q.push_back(v(0, 0, 0, 1, 0, 2'b01, 1, 1, 0, 0));
            I_SUB:    exp_q.push_back(v(0, 0, 0, 1, 0, 2'b10, 1, 1, 0, 0));
            I_AND:    exp_q.push_back(v(0, 0, 0, 1, 0, 2'b11, 1, 1, 0, 0));
            I_OR:     exp_q.push_back(v(0, 0, 0, 1, 0, 2'b00, 1, 1, 0, 0));
            I_BRANCH: exp_q.push_back(v(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0));
            I_BZERO, I_BNZERO, I_BNEG, I_BNNEG: begin
                if (ins == I_BZERO)  t = z;
                if (ins == I_BNZERO) t = !z;
                if (ins == I_BNEG)   t = n;
                if (ins == I_BNNEG)  t = !n;
                exp_q.push_back(v(t, t, 0, 0, 0, 2'b00, 0, 0, 0, 0));
            end
            default: ;  // NOP and HALT end after DECODE
        endcase
    endfunction

    // Drive one instruction's inputs and record outputs for ncyc cycles.
    task automatic collect(input int k, input decoded_instruction_type ins,
                           input logic z, input logic n, input int ncyc);
        dec[k] = ins;
        zf[k]  = z;
        nf[k]  = n;
        uo[k]  = 1'($urandom_range(0, 1));
        so[k]  = 1'($urandom_range(0, 1));
        got_q.delete();
        repeat (ncyc) begin
            got_q.push_back(get_obs(k));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int k);
        rst[k] = 1'b1;
        @(posedge clk);
        #1;
        rst[k] = 1'b0;
    endtask

    task automatic test_reset;
        vec_t rv;
        rv = v(0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0);
        do_reset(1);
        build_exp(I_NOP, 2, 0, 0);
        collect(1, I_NOP, 0, 0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL reset_pre_nop cyc%0d got=%b exp=%b", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (get_cnt(1) !== 16'd1) begin
            miscompares++;
            $display("FAIL reset_pre_count got=%0d exp=1", get_cnt(1));
        end
        // advance into LD_WAIT: two FETCH, LATCH, DECODE
        collect(1, I_LOAD, 0, 0, 4);
        vectors++;
        if (get_obs(1) !== v(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL reset_in_ldwait got=%b exp=%b", get_obs(1), v(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
        end
        #2;
        rst[1] = 1'b1;
        #1;
        vectors++;
        if (get_obs(1) !== rv || get_cnt(1) !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_async got=%b/%0d exp=%b/0", get_obs(1), get_cnt(1), rv);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (get_obs(1) !== rv || get_cnt(1) !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_held got=%b/%0d exp=%b/0", get_obs(1), get_cnt(1), rv);
        end
        rst[1] = 1'b0;
        build_exp(I_MOVE, 2, 0, 0);
        collect(1, I_MOVE, 0, 0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL reset_after_move cyc%0d got=%b exp=%b", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (get_cnt(1) !== 16'd1) begin
            miscompares++;
            $display("FAIL reset_after_count got=%0d exp=1", get_cnt(1));
        end
    endtask

    task automatic test_add;
        do_reset(0);
        build_exp(I_ADD, 1, 0, 0);
        collect(0, I_ADD, 0, 0, 4);
        vectors++;
        if (exp_q.size() !== 4) begin
            miscompares++;
            $display("FAIL add_length got=%0d exp=4", exp_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL add cyc%0d got=%b exp=%b", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (get_obs(0) !== v(0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0) || get_cnt(0) !== 16'd1) begin
            miscompares++;
            $display("FAIL add_next_fetch got=%b/%0d exp=fetch/1", get_obs(0), get_cnt(0));
        end
    endtask

    task automatic test_load;
        do_reset(1);
        vectors++;
        if (get_cnt(1) !== 16'd0) begin
            miscompares++;
            $display("FAIL load_count_before got=%0d exp=0", get_cnt(1));
        end
        build_exp(I_LOAD, 2, 0, 0);
        collect(1, I_LOAD, 0, 0, 7);
        for (int i = 0; i < 7; i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL load cyc%0d got=%b exp=%b", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (get_obs(1) !== v(0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0) || get_cnt(1) !== 16'd1) begin
            miscompares++;
            $display("FAIL load_next_fetch got=%b/%0d exp=fetch/1", get_obs(1), get_cnt(1));
        end
    endtask

    task automatic test_branch_cond;
        decoded_instruction_type ins [4] = '{I_BZERO, I_BZERO, I_BNNEG, I_BNNEG};
        logic                    z   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic                    n   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic                    tk  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vec_t                    last;
        do_reset(0);
        for (int j = 0; j < 4; j++) begin
            build_exp(ins[j], 1, z[j], n[j]);
            collect(0, ins[j], z[j], n[j], exp_q.size());
            last = got_q[exp_q.size() - 1];
            vectors++;
            if (last[10] !== tk[j] || last[9] !== tk[j] || last[7] !== 1'b0) begin
                miscompares++;
                $display("FAIL brcond%0d got=%b exp_taken=%b", j, last, tk[j]);
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                vectors++;
                if (got_q[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL brcond%0d_trace cyc%0d got=%b exp=%b", j, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_move_store;
        do_reset(0);
        build_exp(I_MOVE, 1, 1, 1);
        collect(0, I_MOVE, 1, 1, exp_q.size());
        vectors++;
        if (got_q[3] !== v(0, 0, 0, 1, 0, 2'b00, 1, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL move got=%b exp=%b", got_q[3], v(0, 0, 0, 1, 0, 2'b00, 1, 0, 0, 0));
        end
        build_exp(I_STORE, 1, 0, 0);
        collect(0, I_STORE, 0, 0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL store cyc%0d got=%b exp=%b", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (get_obs(0) !== v(0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0) || get_cnt(0) !== 16'd2) begin
            miscompares++;
            $display("FAIL store_after got=%b/%0d exp=fetch/2", get_obs(0), get_cnt(0));
        end
    endtask

    task automatic test_halt;
        vec_t hv;
        hv = v(0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 1);
        do_reset(0);
        build_exp(I_NOP, 1, 0, 0);
        collect(0, I_NOP, 0, 0, exp_q.size());
        build_exp(I_HALT, 1, 0, 0);
        collect(0, I_HALT, 0, 0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL halt_entry cyc%0d got=%b exp=%b", i, got_q[i], exp_q[i]);
            end
        end
        // scramble inputs while halted; HALT must hold regardless
        for (int c = 0; c < 100; c++) begin
            vectors++;
            if (get_obs(0) !== hv || get_cnt(0) !== 16'd2) begin
                miscompares++;
                $display("FAIL halt_hold cyc%0d got=%b/%0d exp=%b/2", c, get_obs(0), get_cnt(0), hv);
            end
            collect(0, decoded_instruction_type'(4'($urandom_range(0, 13))),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
        end
    endtask

    task automatic test_wrap;
        do_reset(2);
        for (int j = 0; j < 17; j++) begin
            build_exp(I_NOP, 1, 0, 0);
            collect(2, I_NOP, 0, 0, exp_q.size());
        end
        vectors++;
        if (get_cnt(2) !== 16'd1) begin
            miscompares++;
            $display("FAIL wrap_count got=%0d exp=1", get_cnt(2));
        end
    endtask

    task automatic test_back_to_back;
        decoded_instruction_type ins;
        logic                    z, n;
        int unsigned             model_cnt;
        for (int k = 0; k < 3; k++) begin
            do_reset(k);
            model_cnt = 0;
            for (int j = 0; j < 60; j++) begin
                ins = decoded_instruction_type'(4'($urandom_range(0, 12)));
                z   = 1'($urandom_range(0, 1));
                n   = 1'($urandom_range(0, 1));
                build_exp(ins, wk[k], z, n);
                collect(k, ins, z, n, exp_q.size());
                model_cnt = (model_cnt + 1) % (32'd1 << cwk[k]);
                for (int i = 0; i < exp_q.size(); i++) begin
                    vectors++;
                    if (got_q[i] !== exp_q[i]) begin
                        miscompares++;
                        $display("FAIL rand k%0d n%0d %s cyc%0d got=%b exp=%b",
                                 k, j, ins.name(), i, got_q[i], exp_q[i]);
                    end
                end
                vectors++;
                if (get_cnt(k) !== 16'(model_cnt)) begin
                    miscompares++;
                    $display("FAIL rand_count k%0d n%0d got=%0d exp=%0d", k, j, get_cnt(k), model_cnt);
                end
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1;
            dec[k] = I_NOP;
            zf[k]  = 1'b0;
            nf[k]  = 1'b0;
            uo[k]  = 1'b0;
            so[k]  = 1'b0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_add();
        test_load();
        test_branch_cond();
        test_move_store();
        test_halt();
        test_wrap();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
